// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DIV_FIX = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_DIV_CYCLES = 32;

  // Two's-complement magnitude when en is set, raw value otherwise.
  // 32'h8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_cpu_div_core.sv
// Unsigned iterative restoring divider: one quotient bit per step, MSB first.
module mips_cpu_div_core (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;   // dividend shifts out the top, quotient bits shift in
  logic [31:0] r_dvs;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_borrow;

  // Partial remainder after the shift is < 2*divisor, so 33 bits suffice and
  // bit 32 of the difference is exactly the borrow.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_borrow = w_diff[32];

  // Load operands or perform one restoring step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_borrow ? w_shift[31:0] : w_diff[31:0];
      r_quo <= {r_quo[30:0], ~w_borrow};
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multiply/divide unit with HI/LO: single-cycle multiply, 33-cycle divide.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  muldiv_state_t r_state, w_state_nxt;
  muldiv_op_t    w_op;

  logic [4:0]  r_cnt;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_is_div;
  logic        w_signed;
  logic        w_b_zero;
  logic        w_div_load;
  logic        w_div_step;
  logic        w_imm_done;
  logic        w_last;

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic        [31:0] w_quo;
  logic        [31:0] w_rem;

  assign w_op     = muldiv_op_t'(i_op);
  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_signed = (w_op == OP_DIV);
  assign w_b_zero = (i_b == 32'd0);
  assign w_last   = (r_cnt == 5'(MULDIV_DIV_CYCLES - 1));

  assign w_prod_s = $signed(i_a) * $signed(i_b);
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  mips_cpu_div_core u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (mag32(i_a, w_signed)),
    .i_divisor  (mag32(i_b, w_signed)),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and divider control; codes 6-7 fall through as no-ops.
  always_comb begin
    w_state_nxt = r_state;
    w_div_load  = 1'b0;
    w_div_step  = 1'b0;
    w_imm_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          case (w_op)
            OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO: w_imm_done = 1'b1;
            OP_DIV, OP_DIVU: begin
              if (w_b_zero) begin
                w_imm_done = 1'b1;
              end else begin
                w_div_load  = 1'b1;
                w_state_nxt = ST_DIV_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DIV_RUN: begin
        w_div_step = 1'b1;
        if (w_last) w_state_nxt = ST_DIV_FIX;
      end
      ST_DIV_FIX: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Iteration counter and result sign flags captured at divide start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_div_load) begin
      r_cnt   <= '0;
      r_q_neg <= w_signed & (i_a[31] ^ i_b[31]);
      r_r_neg <= w_signed & i_a[31];
    end else if (w_div_step) begin
      r_cnt   <= r_cnt + 5'd1;
    end
  end

  // HI/LO update: immediate ops at the accept edge, divide in DIV_FIX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept) begin
      case (w_op)
        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
        OP_DIV, OP_DIVU: begin
          if (w_b_zero) begin
            r_hi <= i_a;
            r_lo <= 32'hFFFF_FFFF;
          end
        end
        OP_MTHI:  r_hi <= i_a;
        OP_MTLO:  r_lo <= i_a;
        default: ;
      endcase
    end else if (r_state == ST_DIV_FIX) begin
      r_lo <= r_q_neg ? (~w_quo + 32'd1) : w_quo;
      r_hi <= r_r_neg ? (~w_rem + 32'd1) : w_rem;
    end
  end

  // Registered one-cycle completion pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_done <= 1'b0;
    else          r_done <= w_imm_done | (r_state == ST_DIV_FIX);
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
